// File: rtl/pll_lock_sequencer.sv
// PLL reset / lock-acquisition / stabilisation sequencer on the reference clock.
// Optional `PLL_LOSS_COUNTER_EN adds a saturating count of lock losses seen in RUN.
module pll_lock_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65535,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRY      = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart_req,
  output logic       pll_rst,
  output logic       user_rst,
  output logic       ready,
  output logic       fault,
  output logic [7:0] retry_count
`ifdef PLL_LOSS_COUNTER_EN
  ,
  output logic [7:0] loss_count
`endif
);

  localparam int MAX_T01 = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_T   = (MAX_T01 > STABLE_CYCLES) ? MAX_T01 : STABLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_T) + 1;

  localparam logic [CNT_W-1:0] PRST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STBL_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [7:0]       MAX_R     = 8'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_PLLRST = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_q, retry_d;
  logic [7:0]       retry_inc;
  logic             sync1_q, locked_s_q;
  logic             pll_rst_q, user_rst_q, ready_q, fault_q;

  // Two-flop synchroniser for the asynchronous PLL lock indication
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= pll_locked;
      locked_s_q <= sync1_q;
    end
  end

  assign retry_inc = sat_inc(retry_q);

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    if (restart_req) begin
      state_d = S_PLLRST;
      retry_d = 8'd0;
    end else begin
      case (state_q)
        S_PLLRST: if (cnt_q == PRST_LAST) state_d = S_WAIT;
        S_WAIT: begin
          if (locked_s_q) begin
            state_d = S_STABLE;
          end else if (cnt_q == TOUT_LAST) begin
            retry_d = retry_inc;
            state_d = (retry_inc == MAX_R) ? S_FAULT : S_PLLRST;
          end
        end
        S_STABLE: begin
          if (!locked_s_q)              state_d = S_WAIT;
          else if (cnt_q == STBL_LAST)  state_d = S_RUN;
        end
        // Lock loss after a clean start is not a failed attempt
        S_RUN: begin
          if (!locked_s_q) begin
            state_d = S_PLLRST;
            retry_d = 8'd0;
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_PLLRST;
      endcase
    end
  end

  // Counter restarts on every entry, including a restart that re-enters PLLRST
  always_comb begin
    cnt_d = cnt_q;
    if (restart_req || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q == S_PLLRST) || (state_q == S_WAIT) || (state_q == S_STABLE)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q    <= S_PLLRST;
      cnt_q      <= '0;
      retry_q    <= 8'd0;
      pll_rst_q  <= 1'b1;
      user_rst_q <= 1'b1;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      pll_rst_q  <= (state_d == S_PLLRST) || (state_d == S_FAULT);
      user_rst_q <= (state_d != S_RUN);
      ready_q    <= (state_d == S_RUN);
      fault_q    <= (state_d == S_FAULT);
    end
  end

  assign pll_rst     = pll_rst_q;
  assign user_rst    = user_rst_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;

`ifdef PLL_LOSS_COUNTER_EN
  logic [7:0] loss_q, loss_d;
  logic       lock_lost;

  assign lock_lost = (state_q == S_RUN) && !locked_s_q && !restart_req;
  assign loss_d    = lock_lost ? sat_inc(loss_q) : loss_q;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) loss_q <= 8'd0;
    else     loss_q <= loss_d;
  end

  assign loss_count = loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: elapsed-time phase model checked every cycle,
// plus directed scenario checks with hand-derived cycle positions.
module tb_pll_lock_sequencer;

  localparam int P_RST  = 4;
  localparam int P_TOUT = 20;
  localparam int P_STBL = 8;
  localparam int P_MAXR = 2;

  logic       refclk = 1'b0;
  logic       rst = 1'b0;
  logic       pll_locked = 1'b0;
  logic       restart_req = 1'b0;
  logic       pll_rst, user_rst, ready, fault;
  logic [7:0] retry_count;
`ifdef PLL_LOSS_COUNTER_EN
  logic [7:0] loss_count;
`endif

  pll_lock_sequencer #(
    .PLL_RST_CYCLES(P_RST),
    .LOCK_TIMEOUT  (P_TOUT),
    .STABLE_CYCLES (P_STBL),
    .MAX_RETRY     (P_MAXR)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .restart_req(restart_req),
    .pll_rst    (pll_rst),
    .user_rst   (user_rst),
    .ready      (ready),
    .fault      (fault),
    .retry_count(retry_count)
`ifdef PLL_LOSS_COUNTER_EN
    ,
    .loss_count (loss_count)
`endif
  );

  always #5 refclk = ~refclk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, got, exp);
  endtask

  // Model: phase plus the edge at which it was entered; exits are decided by elapsed edges.
  localparam int PH_RST = 0, PH_WAIT = 1, PH_SETTLE = 2, PH_RUN = 3, PH_FAULT = 4;
  int m_edge, m_enter, m_phase, m_retry, m_loss;
  bit m_hist0, m_hist1;

  task automatic model_step();
    bit ls;
    int spent, nxt;
    if (rst) begin
      m_edge = 0; m_enter = 0; m_phase = PH_RST; m_retry = 0; m_loss = 0;
      m_hist0 = 1'b0; m_hist1 = 1'b0;
    end else begin
      m_edge++;
      ls = m_hist1;
      m_hist1 = m_hist0;
      m_hist0 = pll_locked;
      spent = m_edge - m_enter;
      nxt = m_phase;
      if (restart_req) begin
        nxt = PH_RST;
        m_retry = 0;
        m_enter = m_edge;
      end else if (m_phase == PH_RST) begin
        if (spent == P_RST) nxt = PH_WAIT;
      end else if (m_phase == PH_WAIT) begin
        if (ls) nxt = PH_SETTLE;
        else if (spent == P_TOUT) begin
          m_retry = (m_retry >= 255) ? 255 : m_retry + 1;
          nxt = (m_retry == P_MAXR) ? PH_FAULT : PH_RST;
        end
      end else if (m_phase == PH_SETTLE) begin
        if (!ls) nxt = PH_WAIT;
        else if (spent == P_STBL) nxt = PH_RUN;
      end else if (m_phase == PH_RUN) begin
        if (!ls) begin
          nxt = PH_RST;
          m_retry = 0;
          m_loss = (m_loss >= 255) ? 255 : m_loss + 1;
        end
      end
      if (nxt != m_phase) m_enter = m_edge;
      m_phase = nxt;
    end
  endtask

  always @(posedge refclk or posedge rst) model_step();

  always @(negedge refclk) begin
    logic [3:0] got_f, exp_f;
    bit ok;
    got_f = {pll_rst, user_rst, ready, fault};
    exp_f = {(m_phase == PH_RST) || (m_phase == PH_FAULT), m_phase != PH_RUN,
             m_phase == PH_RUN, m_phase == PH_FAULT};
    ok = (got_f === exp_f) && (retry_count === 8'(m_retry));
`ifdef PLL_LOSS_COUNTER_EN
    ok = ok && (loss_count === 8'(m_loss));
`endif
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL cycle_model t=%0t: got prst/urst/rdy/flt=%b retry=%0d, want %b retry=%0d",
                  $time, got_f, retry_count, exp_f, m_retry);
  end

  initial begin
    int hi;
    #1 rst = 1'b1;
    repeat (3) @(negedge refclk);
    chk("reset_pll_rst", pll_rst, 1);
    chk("reset_user_rst", user_rst, 1);
    chk("reset_ready", ready, 0);
    chk("reset_fault", fault, 0);
    chk("reset_retry", retry_count, 0);

    // Lock acquisition after release
    rst = 1'b0;
    hi = 0;
    for (int i = 0; i <= 21; i++) begin
      if (i > 0) @(negedge refclk);
      if (pll_rst) hi++;
      if (i == 10) pll_locked = 1'b1;
      if (i == 20) chk("t1_ready_early", ready, 0);
    end
    chk("t1_pll_rst_len", hi, 4);
    chk("t1_ready", ready, 1);
    chk("t1_user_rst", user_rst, 0);
    chk("t1_retry", retry_count, 0);

    // Lock loss while running
    repeat (2) @(negedge refclk);
    pll_locked = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      @(negedge refclk);
      if (j == 2) chk("t4_ready_hold", ready, 1);
    end
    chk("t4_user_rst", user_rst, 1);
    chk("t4_ready", ready, 0);
    chk("t4_pll_rst", pll_rst, 1);
    chk("t4_retry", retry_count, 0);
`ifdef PLL_LOSS_COUNTER_EN
    chk("t4_loss_count", loss_count, 1);
`endif

    // Lock glitch during stabilisation
    for (int r = 1; r <= 26; r++) begin
      @(negedge refclk);
      if (r == 4)  pll_locked = 1'b1;
      if (r == 12) pll_locked = 1'b0;
      if (r == 15) begin
        chk("t3_no_run_after_glitch", ready, 0);
        pll_locked = 1'b1;
      end
      if (r == 25) chk("t3_ready_early", ready, 0);
    end
    chk("t3_ready", ready, 1);
    chk("t3_retry", retry_count, 0);

    // Two timeouts lead to fault, restart clears it
    repeat (2) @(negedge refclk);
    pll_locked = 1'b0;
    hi = 0;
    for (int d = 1; d <= 61; d++) begin
      @(negedge refclk);
      if (d >= 3 && d <= 50 && pll_rst) hi++;
      if (d == 26) chk("t2_retry_before", retry_count, 0);
      if (d == 27) begin
        chk("t2_retry_first", retry_count, 1);
        chk("t2_pll_rst_retry", pll_rst, 1);
      end
      if (d == 50) chk("t2_fault_early", fault, 0);
      if (d == 51) begin
        chk("t2_fault", fault, 1);
        chk("t2_fault_pll_rst", pll_rst, 1);
        chk("t2_fault_retry", retry_count, 2);
      end
      if (d == 60) begin
        chk("t2_fault_held", fault, 1);
        restart_req = 1'b1;
      end
      if (d == 61) restart_req = 1'b0;
    end
    chk("t2_pll_rst_pulses", hi, 8);
    chk("t2_restart_fault", fault, 0);
    chk("t2_restart_retry", retry_count, 0);
    chk("t2_restart_pll_rst", pll_rst, 1);

    // Restart beats a simultaneous timeout; restart inside PLLRST re-arms its count
    for (int e = 1; e <= 55; e++) begin
      @(negedge refclk);
      if (e == 47) begin
        chk("t5_retry_before", retry_count, 1);
        restart_req = 1'b1;
      end
      if (e == 48) begin
        restart_req = 1'b0;
        chk("t5_retry", retry_count, 0);
        chk("t5_fault", fault, 0);
        chk("t5_pll_rst", pll_rst, 1);
      end
      if (e == 50) restart_req = 1'b1;
      if (e == 51) restart_req = 1'b0;
      if (e == 54) chk("t5_pllrst_rearmed", pll_rst, 1);
    end
    chk("t5_wait_entry", pll_rst, 0);

    // Asynchronous reset mid-stabilisation
    pll_locked = 1'b1;
    repeat (6) @(negedge refclk);
    chk("t6_pll_rst_before", pll_rst, 0);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_pll_rst", pll_rst, 1);
    chk("t6_async_user_rst", user_rst, 1);
    chk("t6_async_ready", ready, 0);
    chk("t6_async_fault", fault, 0);
    chk("t6_async_retry", retry_count, 0);
`ifdef PLL_LOSS_COUNTER_EN
    chk("t6_async_loss", loss_count, 0);
`endif
    repeat (2) @(negedge refclk);
    rst = 1'b0;
    repeat (30) @(negedge refclk);
    chk("t6_relock_ready", ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
